// File: rtl/mult_ctrl.sv
// -----------------------------------------------------------------------------
// mult_ctrl
// Sequencing FSM for the 32-bit shift-add multiplier datapath.
// A start request loads the operands (INIT). The FSM then runs N_ITER
// iterations. Each iteration is EVAL, then ADD when the product LSB is 1,
// then SHIFT. The datapath done32 flag is cross-checked against the internal
// iteration counter in every EVAL cycle. Any disagreement sets the sticky err.
//
// Ports:
//   clk     rising-edge clock shared with the datapath
//   rst_n   asynchronous active-low reset
//   start   multiply request, accepted only while ready=1
//   abort   synchronous cancel of an operation in flight
//   lsb     product bit 0 from the datapath
//   done32  datapath counter-at-31 flag
//   init    datapath load strobe (INIT)
//   regWr   datapath upper-product write strobe (ADD)
//   shiftR  datapath shift/count strobe (SHIFT)
//   ready   idle and able to accept start
//   busy    operation in progress (INIT/EVAL/ADD/SHIFT)
//   done    one-cycle completion pulse (FIN)
//   err     sticky done32/counter mismatch flag
//   iter    completed shift count
// -----------------------------------------------------------------------------
module mult_ctrl #(
    parameter int N_ITER = 32,
    parameter int CNT_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             lsb,
    input  logic             done32,
    output logic             init,
    output logic             regWr,
    output logic             shiftR,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    // Count value seen during the final iteration.
    // The SHIFT leaving this value ends the operation.
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(N_ITER - 1);

    logic [2:0]       state_r;
    logic [2:0]       state_next_s;
    logic [CNT_W-1:0] iter_r;
    logic [CNT_W-1:0] iter_next_s;
    logic             err_r;
    logic             err_next_s;
    logic             accept_s;
    logic             mismatch_s;
    logic             init_r;
    logic             regwr_r;
    logic             shiftr_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;

    assign accept_s   = (state_r == S_IDLE) && start;
    // Expected done32 is 1 only in the last iteration.
    assign mismatch_s = (state_r == S_EVAL) && (done32 != (iter_r == ITER_LAST));

    // Next-state decode. Abort is honoured only in the four busy states.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_INIT;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_INIT: begin
                if (abort) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_EVAL;
                end
            end
            S_EVAL: begin
                if (abort) begin
                    state_next_s = S_IDLE;
                end else if (lsb) begin
                    state_next_s = S_ADD;
                end else begin
                    state_next_s = S_SHIFT;
                end
            end
            S_ADD: begin
                if (abort) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_next_s = S_IDLE;
                end else if (iter_r == ITER_LAST) begin
                    state_next_s = S_FIN;
                end else begin
                    state_next_s = S_EVAL;
                end
            end
            S_FIN: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Iteration counter and sticky error update.
    // The shift taken in an aborted SHIFT cycle still counts.
    always_comb begin
        iter_next_s = iter_r;
        err_next_s  = err_r;
        if (accept_s) begin
            iter_next_s = {CNT_W{1'b0}};
            err_next_s  = 1'b0;
        end else begin
            if (state_r == S_SHIFT) begin
                iter_next_s = iter_r + CNT_W'(1);
            end else begin
                iter_next_s = iter_r;
            end
            if (mismatch_s) begin
                err_next_s = 1'b1;
            end else begin
                err_next_s = err_r;
            end
        end
    end

    // State, counter and registered Moore outputs.
    // Each output is decoded from the next state, so it matches the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            iter_r   <= {CNT_W{1'b0}};
            err_r    <= 1'b0;
            init_r   <= 1'b0;
            regwr_r  <= 1'b0;
            shiftr_r <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            iter_r   <= iter_next_s;
            err_r    <= err_next_s;
            init_r   <= (state_next_s == S_INIT);
            regwr_r  <= (state_next_s == S_ADD);
            shiftr_r <= (state_next_s == S_SHIFT);
            ready_r  <= (state_next_s == S_IDLE);
            busy_r   <= (state_next_s == S_INIT) || (state_next_s == S_EVAL) ||
                        (state_next_s == S_ADD)  || (state_next_s == S_SHIFT);
            done_r   <= (state_next_s == S_FIN);
        end
    end

    assign init   = init_r;
    assign regWr  = regwr_r;
    assign shiftR = shiftr_r;
    assign ready  = ready_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;
    assign iter   = iter_r;

endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Sequencing FSM for the 32-bit shift-add multiplier datapath. On a start request it loads the operands, then runs 32 add/shift iterations, steering the datapath's `init`, `regWr` and `shiftR` strobes from the product LSB. It exposes a start/ready/done handshake to the ALU top level and cross-checks the datapath's `done32` flag against its own iteration counter.

## Interface
- `N_ITER`, 32: number of add/shift iterations; must match the datapath width.
- `CNT_W`, 6: iteration counter width; must satisfy 2^CNT_W > N_ITER.

- `clk`  in  1  rising-edge clock shared with the datapath.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiply; accepted only when `ready`=1.
- `abort`  in  1  synchronous cancel of an operation in flight.
- `lsb`  in  1  product bit 0 from the datapath (`currProduct[0]`).
- `done32`  in  1  datapath counter-at-31 flag.
- `init`  out  1  datapath load strobe.
- `regWr`  out  1  datapath upper-product write strobe (accept `sum`).
- `shiftR`  out  1  datapath shift/count strobe.
- `ready`  out  1  idle and able to accept `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky `done32`/counter mismatch flag.
- `iter`  out  CNT_W  completed shift count.

## Operation
- States: IDLE, INIT, EVAL, ADD, SHIFT, FIN.
- Strobes are decoded from the registered state only (Moore):
  - `init`=1 only in INIT.
  - `regWr`=1 only in ADD.
  - `shiftR`=1 only in SHIFT.
- At most one strobe is high in any cycle. `regWr` and `shiftR` are never asserted together.
- `ready`=1 only in IDLE. `busy`=1 in INIT, EVAL, ADD and SHIFT. `done`=1 only in FIN.
- Transitions:
  - IDLE → INIT when `start`=1. In the same edge, `iter` is cleared and `err` is cleared.
  - INIT → EVAL.
  - EVAL → ADD if `lsb`=1, else EVAL → SHIFT.
  - ADD → SHIFT.
  - SHIFT → EVAL if `iter`+1 < N_ITER, else SHIFT → FIN. `iter` increments on every SHIFT cycle.
  - FIN → IDLE unconditionally.
- `abort`=1 in INIT, EVAL, ADD or SHIFT forces IDLE at the next edge.
  - No `done` pulse is produced.
  - `iter` holds its value.
  - The strobe belonging to the current state is still asserted during that cycle.
- `abort` is ignored in IDLE and FIN. `start` is ignored in every state except IDLE.
- `done32` check, performed in every EVAL cycle:
  - Expected value is 1 when `iter`=N_ITER-1, and 0 otherwise.
  - A mismatch sets `err` at the next edge.
  - `err` stays set until the next accepted `start` or reset. Sequencing continues regardless.
- `iter` is CNT_W bits wide and never wraps within an operation (maximum value N_ITER).

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State goes to IDLE and `iter`=0.
  - `err`, `done`, `busy`, `init`, `regWr` and `shiftR` are 0; `ready`=1.
- Reset mid-operation: all strobes drop immediately, with no `done`. The datapath is left partially updated and is reloaded by the next INIT.
- Start acceptance: `start` sampled at edge 0 means INIT is active in cycle 1.
- Each iteration takes 2 cycles if `lsb`=0 and 3 cycles if `lsb`=1.
- `busy` duration is 1 + 2·N_ITER + k cycles, where k is the number of 1s in the multiplier:
  - 65 cycles minimum (multiplier 0).
  - 97 cycles maximum (multiplier 0xFFFFFFFF).
- `done` is asserted in the cycle immediately after the last SHIFT. `ready` returns in the following cycle.
- `start` held high continuously gives back-to-back operations with one IDLE cycle between FIN and the next INIT.
- `lsb` is sampled only in EVAL, one cycle after INIT or SHIFT, when the datapath register is settled.

## Test plan
- **Multiplier 0x00000000, start pulse** → `busy` high for 65 cycles; 1 `init`, 0 `regWr`, 32 `shiftR`; `done` pulses once; `iter`=32; `err`=0.
- **Multiplier 0xFFFFFFFF** → `busy` 97 cycles; 32 `regWr` pulses, each immediately followed by `shiftR`; product equals the expected 32-bit result; `err`=0.
- **Multiplier 0x00000005, multiplicand 7** → `regWr` occurs in iterations 0 and 2 only; result 35; `busy` 67 cycles.
- **`abort` in the 10th SHIFT cycle** → IDLE at the next edge; no `done`; `iter`=10; `ready`=1. A following `start` restarts cleanly from INIT with `iter`=0.
- **Datapath `done32` forced high at `iter`=5** → `err`=1 from the cycle after that EVAL; operation still completes with `done`. The next `start` clears `err`.
- **`rst_n` low during ADD** → `regWr` drops immediately, `ready`=1, `iter`=0. `start` pulses while `busy`=1 are ignored, with no state change.
